// File: rtl/uart_to_bram_pkg.sv
// Shared constants and state encodings for the UART-to-BRAM loader.
// The bit-period derivation lives here so the RX path and the loader agree on it.
package uart_to_bram_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ    = 100_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE   = 115_200;
  localparam int unsigned DEFAULT_TOTAL_BYTES = 124;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_WRITE     = 3'd2,
    S_DONE      = 3'd3
  } top_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_to_bram_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB-first shift.
// Emits a one-cycle rx_valid for a good stop bit, or rx_err for a bad one.
module uart_to_bram_rx
  import uart_to_bram_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_serial,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [31:0] LP_BIT_LAST  = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] LP_HALF_LAST = 32'(CLKS_PER_BIT / 2 - 1);

  logic        r_sync1;
  logic        r_sync2;
  rx_state_t   r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_valid;
  logic        r_err;

  rx_state_t   w_state_next;
  logic [31:0] w_cnt_next;
  logic [2:0]  w_bit_idx_next;
  logic [7:0]  w_shift_next;
  logic        w_valid_next;
  logic        w_err_next;

  // Sync flops reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_valid   <= w_valid_next;
      r_err     <= w_err_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 32'd1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_valid_next   = 1'b0;
    w_err_next     = 1'b0;

    case (r_state)
      R_IDLE: begin
        w_cnt_next = '0;
        if (!r_sync2) begin
          w_state_next = R_START;
        end
      end
      R_START: begin
        if (r_cnt == LP_HALF_LAST) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          // A line that is high again at mid start bit was only a glitch.
          w_state_next   = r_sync2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (r_cnt == LP_BIT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {r_sync2, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_next = R_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      R_STOP: begin
        if (r_cnt == LP_BIT_LAST) begin
          w_cnt_next   = '0;
          w_valid_next = r_sync2;
          w_err_next   = ~r_sync2;
          w_state_next = R_IDLE;
        end
      end
      default: begin
        w_state_next = R_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign rx_valid = r_valid;
  assign rx_err   = r_err;
  assign rx_data  = r_shift;

endmodule

// File: rtl/uart_to_bram.sv
// Loads TOTAL_BYTES received UART bytes into a byte-wide BRAM port from address 0.
// Loading only runs once armed by load_start; load_done and frame_err are sticky.
module uart_to_bram
  import uart_to_bram_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD_RATE   = DEFAULT_BAUD_RATE,
  parameter int unsigned TOTAL_BYTES = DEFAULT_TOTAL_BYTES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx_serial,
  input  logic               load_start,
  output logic               ena,
  output logic               wea,
  output logic [31:0]        addr,
  output logic signed [7:0]  din,
  output logic               load_done,
  output logic               frame_err
);

  localparam logic [31:0] LP_LAST_ADDR = 32'(TOTAL_BYTES - 1);

  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_rx_err;

  top_state_t  r_state;
  logic        r_armed;
  logic [31:0] r_addr_ctr;
  logic        r_ena;
  logic        r_wea;
  logic [31:0] r_addr;
  logic [7:0]  r_din;
  logic        r_load_done;
  logic        r_frame_err;

  top_state_t  w_state_next;
  logic        w_armed_next;
  logic [31:0] w_addr_ctr_next;
  logic        w_ena_next;
  logic        w_wea_next;
  logic [31:0] w_addr_next;
  logic [7:0]  w_din_next;
  logic        w_load_done_next;
  logic        w_frame_err_next;

  uart_to_bram_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_serial (rx_serial),
    .rx_valid  (w_rx_valid),
    .rx_data   (w_rx_data),
    .rx_err    (w_rx_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_addr_ctr  <= '0;
      r_ena       <= 1'b0;
      r_wea       <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_load_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_armed     <= w_armed_next;
      r_addr_ctr  <= w_addr_ctr_next;
      r_ena       <= w_ena_next;
      r_wea       <= w_wea_next;
      r_addr      <= w_addr_next;
      r_din       <= w_din_next;
      r_load_done <= w_load_done_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_armed_next     = r_armed | (load_start && (r_state == S_IDLE));
    w_addr_ctr_next  = r_addr_ctr;
    w_ena_next       = 1'b0;
    w_wea_next       = 1'b0;
    w_addr_next      = r_addr;
    w_din_next       = r_din;
    w_load_done_next = r_load_done;
    w_frame_err_next = r_frame_err;

    case (r_state)
      S_IDLE: begin
        if (r_armed) begin
          w_state_next = S_WAIT_BYTE;
        end
      end
      S_WAIT_BYTE: begin
        if (w_rx_valid) begin
          w_din_next   = w_rx_data;
          w_addr_next  = r_addr_ctr;
          w_ena_next   = 1'b1;
          w_wea_next   = 1'b1;
          w_state_next = S_WRITE;
        end else if (w_rx_err) begin
          w_frame_err_next = 1'b1;
        end
      end
      S_WRITE: begin
        // The counter stops at the last address rather than wrapping.
        if (r_addr_ctr == LP_LAST_ADDR) begin
          w_load_done_next = 1'b1;
          w_state_next     = S_DONE;
        end else begin
          w_addr_ctr_next = r_addr_ctr + 32'd1;
          w_state_next    = S_WAIT_BYTE;
        end
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign ena       = r_ena;
  assign wea       = r_wea;
  assign addr      = r_addr;
  assign din       = $signed(r_din);
  assign load_done = r_load_done;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_to_bram.sv
// Bench for uart_to_bram: serialises frames onto rx_serial and scoreboards BRAM writes.
// Uses a short bit period (16 clocks) so full loads stay cheap to simulate.
module tb_uart_to_bram;

  localparam int CLK_FREQ    = 1_600_000;
  localparam int BAUD_RATE   = 100_000;
  localparam int CPB         = CLK_FREQ / BAUD_RATE;
  localparam int TOTAL_BYTES = 124;

  typedef struct {
    logic [31:0]       addr;
    logic signed [7:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rx_serial;
  logic              load_start;
  logic              ena;
  logic              wea;
  logic [31:0]       addr;
  logic signed [7:0] din;
  logic              load_done;
  logic              frame_err;

  wr_t         sb_q[$];
  logic [31:0] exp_addr;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobe_cnt;
  bit          done_pending;
  bit          prev_wea;

  uart_to_bram #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .TOTAL_BYTES (TOTAL_BYTES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_serial  (rx_serial),
    .load_start (load_start),
    .ena        (ena),
    .wea        (wea),
    .addr       (addr),
    .din        (din),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: samples on the falling edge, pops the scoreboard per strobe.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_wea <= 1'b0;
    end else begin
      if (done_pending) begin
        check("load_done_rise", 32'(load_done), 32'd1);
        done_pending = 1'b0;
      end
      if (prev_wea) begin
        check("wea_one_cycle", 32'(wea), 32'd0);
      end
      if (wea) begin
        wr_t e;
        strobe_cnt++;
        $display("WR addr=%0d din=%0d", addr, din);
        check("ena_with_wea", 32'(ena), 32'd1);
        check("expected_write", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("wr_addr", addr, e.addr);
          check("wr_din", 32'(din), 32'(e.data));
        end
        if (addr == 32'(TOTAL_BYTES - 1)) begin
          check("load_done_before", 32'(load_done), 32'd0);
          done_pending = 1'b1;
        end
      end
      prev_wea <= wea;
    end
  end

  task automatic uart_send(input logic [7:0] b, input logic stop_bit, input int nbits,
                           input bit expect_wr);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    if (expect_wr) begin
      sb_q.push_back('{addr: exp_addr, data: $signed(b)});
      exp_addr++;
    end
    @(posedge clk); #1;
    for (int i = 0; i < nbits; i++) begin
      rx_serial = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    $display("TX byte=0x%02h stop=%0b bits=%0d", b, stop_bit, nbits);
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 20 * CPB) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    rx_serial  = 1'b1;
    load_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n      = 1'b1;
    sb_q.delete();
    exp_addr     = '0;
    strobe_cnt   = 0;
    done_pending = 1'b0;
  endtask

  task automatic arm();
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    rx_serial    = 1'b1;
    load_start   = 1'b0;
    exp_addr     = '0;
    strobe_cnt   = 0;
    done_pending = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    #1 reset_n = 1'b1;

    // Unarmed: a byte before load_start is ignored.
    uart_send(8'h11, 1'b1, 10, 1'b0);
    idle_bits(3);
    check("unarmed_no_write", 32'(strobe_cnt), 32'd0);

    // Full load 0x00..0x7B, then an overflow byte.
    arm();
    for (int i = 0; i < TOTAL_BYTES; i++) begin
      uart_send(8'(i), 1'b1, 10, 1'b1);
    end
    drain("full_drain");
    idle_bits(1);
    check("full_strobes", 32'(strobe_cnt), 32'(TOTAL_BYTES));
    check("full_load_done", 32'(load_done), 32'd1);
    check("full_frame_err", 32'(frame_err), 32'd0);
    uart_send(8'h99, 1'b1, 10, 1'b0);
    idle_bits(3);
    check("ovf_strobes", 32'(strobe_cnt), 32'(TOTAL_BYTES));
    check("ovf_addr_hold", addr, 32'(TOTAL_BYTES - 1));
    check("ovf_load_done", 32'(load_done), 32'd1);

    // Signed data.
    do_reset();
    arm();
    uart_send(8'h80, 1'b1, 10, 1'b1);
    uart_send(8'hFF, 1'b1, 10, 1'b1);
    drain("signed_drain");
    check("signed_last_din", 32'(din), 32'hFFFF_FFFF);
    check("signed_strobes", 32'(strobe_cnt), 32'd2);

    // Framing error, then a good byte at address 0.
    do_reset();
    arm();
    uart_send(8'h55, 1'b0, 10, 1'b0);
    idle_bits(2);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_no_write", 32'(strobe_cnt), 32'd0);
    uart_send(8'hA5, 1'b1, 10, 1'b1);
    drain("ferr_drain");
    check("ferr_sticky", 32'(frame_err), 32'd1);
    check("ferr_strobes", 32'(strobe_cnt), 32'd1);

    // Short low glitch on the line.
    do_reset();
    arm();
    @(posedge clk); #1;
    rx_serial = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle_bits(2);
    check("glitch_no_write", 32'(strobe_cnt), 32'd0);
    check("glitch_no_err", 32'(frame_err), 32'd0);
    uart_send(8'h3C, 1'b1, 10, 1'b1);
    drain("glitch_drain");
    check("glitch_strobes", 32'(strobe_cnt), 32'd1);

    // Asynchronous reset in the middle of byte 50.
    do_reset();
    arm();
    for (int i = 0; i < 49; i++) begin
      uart_send(8'(i + 8'h40), 1'b1, 10, 1'b1);
    end
    drain("pre_reset_drain");
    uart_send(8'h31, 1'b1, 4, 1'b0);
    repeat (CPB / 2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ena", 32'(ena), 32'd0);
    check("arst_wea", 32'(wea), 32'd0);
    check("arst_addr", addr, 32'd0);
    check("arst_din", 32'(din), 32'd0);
    check("arst_load_done", 32'(load_done), 32'd0);
    check("arst_frame_err", 32'(frame_err), 32'd0);
    rx_serial = 1'b1;
    do_reset();
    uart_send(8'h77, 1'b1, 10, 1'b0);
    idle_bits(3);
    check("rearm_required", 32'(strobe_cnt), 32'd0);
    arm();
    uart_send(8'h5A, 1'b1, 10, 1'b1);
    drain("rearm_drain");
    check("rearm_strobes", 32'(strobe_cnt), 32'd1);
    check("rearm_addr0", addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_to_bram.md
Name: uart_to_bram

Overview:
Receive-side counterpart of the BRAM-to-UART dump path. Deserialises 8N1 bytes arriving on a UART line and writes them sequentially into a byte-wide BRAM port, starting at address 0. The main use is loading filter coefficients and input samples from the host before the convolution engine starts. Asserts a sticky load_done once TOTAL_BYTES valid bytes have been written.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, UART bit rate
TOTAL_BYTES, 124, number of bytes to write before load_done
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (868), derived local constant, not overridable

Ports:
clk  input  1  single system clock; all logic is rising-edge
reset_n  input  1  asynchronous active-low reset; resets every flop in the block, including the RX sub-module
rx_serial  input  1  asynchronous UART line; idles high
load_start  input  1  arm pulse or level; latched internally (sticky until reset)
ena  output  1  BRAM port enable
wea  output  1  BRAM write enable
addr  output  32  BRAM byte address
din  output  8  signed BRAM write data
load_done  output  1  sticky high after the last byte is written
frame_err  output  1  sticky high on any stop-bit error

Behaviour:
- Reset (reset_n=0, asynchronous): ena=0, wea=0, addr=0, din=0, load_done=0, frame_err=0, internal addr_ctr=0, arm latch=0, FSM=S_IDLE, RX=R_IDLE.
- rx_serial passes through a 2-flop synchroniser (sync flops reset to 1). All RX sampling uses the synchronised value.
- RX FSM (sub-module):
  - R_IDLE: on synced line=0, go to R_START and clear the baud counter.
  - R_START: at count CLKS_PER_BIT/2-1 (433), resample the line. If 0, go to R_DATA. If 1, treat it as a glitch and return to R_IDLE with no output.
  - R_DATA: sample every CLKS_PER_BIT clocks. Shift the bits in LSB first. After 8 bits, go to R_STOP.
  - R_STOP: sample after CLKS_PER_BIT clocks. If the line is 1, pulse rx_valid for 1 cycle with rx_data. If 0, pulse rx_err for 1 cycle. Either way, return to R_IDLE.
  - rx_valid and rx_err are never asserted together.
- Top FSM:
  - S_IDLE: wait for the arm latch. While unarmed, rx_valid and rx_err are ignored.
  - S_WAIT_BYTE: on rx_valid, register din<=rx_data, addr<=addr_ctr, ena<=1, wea<=1, and go to S_WRITE. On rx_err, set frame_err=1, stay in S_WAIT_BYTE, and do not advance addr_ctr.
  - S_WRITE: ena<=0, wea<=0 (write strobe is exactly 1 cycle). If addr_ctr==TOTAL_BYTES-1, set load_done<=1 and go to S_DONE. Otherwise increment addr_ctr and return to S_WAIT_BYTE.
  - S_DONE: terminal. All further RX bytes are discarded; ena and wea stay 0; addr holds TOTAL_BYTES-1.
- Latency: the write strobe rises on the clock after the rx_valid pulse. load_done rises 1 cycle after the final strobe.
- Back-to-back bytes: the minimum gap between rx_valid pulses is about 9.5 bit times, so no buffering is needed and a byte is never dropped while armed.
- addr_ctr never exceeds TOTAL_BYTES-1; there is no wrap-around.
- Reset mid-frame or mid-load aborts immediately. The next load restarts at address 0 and requires a fresh load_start.
- load_start asserted in any state other than S_IDLE has no effect.

Decomposition:
- Shared package/header holds CLKS_PER_BIT derivation, the default CLK_FREQ/BAUD_RATE, TOTAL_BYTES, and the state encodings (top FSM 3 bits, RX FSM 2 bits).
- One sub-module: uart_rx (synchroniser, baud counter, shift register, rx_valid/rx_data/rx_err). It mirrors the existing uart_tx and takes the same CLK_FREQ/BAUD_RATE parameters.
- uart_to_bram holds the arm latch, top FSM and address counter.

Test Plan:
- Full load: pulse load_start, then send bytes 0x00..0x7B at 115200 baud. Expect 124 single-cycle wea strobes with addr=n and din=n. load_done rises 1 cycle after the addr=123 strobe; frame_err stays 0.
- Signed data: send 0x80 then 0xFF. Expect din=-128 at addr 0 and din=-1 at addr 1.
- Framing error: send 0x55 with stop bit=0, then 0xA5 valid. Expect frame_err=1, no strobe for 0x55, and 0xA5 written at addr 0.
- Glitch: drive rx low for 200 clocks, then high. Expect no rx_valid, no rx_err and no strobe. A following 0x3C is written at addr 0.
- Unarmed and overflow: send 0x11 before load_start and expect no write. After a complete 124-byte load, send a 125th byte 0x99 and expect no strobe, with addr staying 123.
- Async reset: assert reset_n=0 mid-bit during byte 50. All outputs are 0 within the same cycle. After release and re-arm, the next byte is written at addr 0.
